// File: rtl/armleocpu_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state width and state type.
package armleocpu_defines;

  localparam int unsigned DIV_STATE_W = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_CALC = 2'd1,
    DIV_STATE_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/armleocpu_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational.
module armleocpu_divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  // The shifted remainder keeps the bit that falls out of r, so a divisor
  // above 2^(WIDTH-1) still compares correctly.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtract; the top bit of diff is the borrow.
  always_comb begin
    shifted = {r, q_msb};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    r_next  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/armleocpu_divider.sv
// Iterative unsigned divider (DIVU/REMU), restoring radix-2, one quotient bit
// per clock. Requester holds valid until the one-cycle ready pulse.
// Optional macro ARMLEOCPU_DIVIDER_EARLY_EXIT_EN: finish immediately when
// dividend < divisor (nonzero divisor); results are identical either way.
module armleocpu_divider
  import armleocpu_defines::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             division_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t state, next_state;

  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;

  logic [WIDTH-1:0] r_next;
  logic             q_bit;

  logic zero_div;
  logic early_exit;
  logic fast_done;
  logic accept;
  logic step_en;
  logic publish;

  armleocpu_divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r      (r),
    .q_msb  (q[WIDTH-1]),
    .divisor(d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign zero_div = (divisor == '0);
`ifdef ARMLEOCPU_DIVIDER_EARLY_EXIT_EN
  assign early_exit = (dividend < divisor);
`else
  assign early_exit = 1'b0;
`endif
  assign fast_done = zero_div | early_exit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_STATE_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes.
  // Fast results are published at accept, so DONE only publishes when ready
  // is not already high; a high ready in IDLE marks the consumption cycle of
  // the same request and blocks a re-accept.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    step_en    = 1'b0;
    publish    = 1'b0;
    case (state)
      DIV_STATE_IDLE: begin
        if (valid && !ready) begin
          accept     = 1'b1;
          next_state = fast_done ? DIV_STATE_DONE : DIV_STATE_CALC;
        end
      end
      DIV_STATE_CALC: begin
        if (!valid) begin
          next_state = DIV_STATE_IDLE;
        end else begin
          step_en = 1'b1;
          if (counter == LAST_STEP) begin
            next_state = DIV_STATE_DONE;
          end
        end
      end
      DIV_STATE_DONE: begin
        publish    = !ready;
        next_state = DIV_STATE_IDLE;
      end
      default: next_state = DIV_STATE_IDLE;
    endcase
  end

  // Working shift register, counter and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter          <= '0;
      r                <= '0;
      q                <= '0;
      d                <= '0;
      ready            <= 1'b0;
      division_by_zero <= 1'b0;
      quotient         <= '0;
      remainder        <= '0;
    end else begin
      ready <= publish | (accept & fast_done);
      if (accept) begin
        d       <= divisor;
        q       <= dividend;
        r       <= '0;
        counter <= '0;
        if (fast_done) begin
          quotient         <= zero_div ? '1 : '0;
          remainder        <= dividend;
          division_by_zero <= zero_div;
        end
      end
      if (step_en) begin
        r       <= r_next;
        q       <= {q[WIDTH-2:0], q_bit};
        counter <= counter + CNT_W'(1);
      end
      if (publish) begin
        quotient         <= q;
        remainder        <= r;
        division_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_divider.sv
// Self-checking bench for armleocpu_divider: directed cases plus randomized
// operands against an arithmetic reference model.
module tb_armleocpu_divider;

  localparam int unsigned W = 32;
  localparam int unsigned FULL_LAT = W + 2;

  logic         clk;
  logic         rst;
  logic         valid;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         division_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks   = 0;
  int failures = 0;

  armleocpu_divider #(
    .WIDTH(W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .valid           (valid),
    .dividend        (dividend),
    .divisor         (divisor),
    .ready           (ready),
    .division_by_zero(division_by_zero),
    .quotient        (quotient),
    .remainder       (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V DIVU/REMU semantics.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Edges from the accept edge (counted as 1) up to the edge after which ready is seen.
  function automatic int nominal_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return 1;
`ifdef ARMLEOCPU_DIVIDER_EARLY_EXIT_EN
    if (a < b) return 1;
`endif
    return FULL_LAT;
  endfunction

  // Issue one request; called away from the clock edge. With drop=0 valid stays
  // high after ready so the next call runs back-to-back.
  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input bit drop, input bit scramble);
    logic [W-1:0] eq, er;
    logic         ez;
    int           edges;
    ref_div(a, b, eq, er, ez);
    dividend = a;
    divisor  = b;
    valid    = 1'b1;
    edges    = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready) break;
      if (scramble) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
    check({tag, "_q"}, 64'(quotient), 64'(eq));
    check({tag, "_r"}, 64'(remainder), 64'(er));
    check({tag, "_dbz"}, 64'(division_by_zero), 64'(ez));
    if (drop) begin
      valid = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(ready), 64'd0);
      check({tag, "_hold_q"}, 64'(quotient), 64'(eq));
      check({tag, "_hold_r"}, 64'(remainder), 64'(er));
    end
  endtask

  // Start a long division, interrupt it after 10 iterations (by valid or rst)
  // and make sure no ready ever appears.
  task automatic abort_div(input string tag, input bit use_rst,
                           input logic [W-1:0] hq, input logic [W-1:0] hr);
    int pulses;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_1234;
    valid    = 1'b1;
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) rst = 1'b1;
    else valid = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    valid  = 1'b0;
    pulses = (ready) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
    end
    check({tag, "_no_ready"}, 64'(pulses), 64'd0);
    check({tag, "_q"}, 64'(quotient), 64'(hq));
    check({tag, "_r"}, 64'(remainder), 64'(hr));
    check({tag, "_dbz"}, 64'(division_by_zero), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst      = 1'b1;
    valid    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_dbz", 64'(division_by_zero), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_div("d3392_64", 32'd3392, 32'd64, nominal_lat(32'd3392, 32'd64), 1'b1, 1'b0);
    check("d3392_64_full_lat", 64'(nominal_lat(32'd3392, 32'd64)), 64'(FULL_LAT));
    do_div("d1_max", 32'h0000_0001, 32'hFFFF_FFFF, nominal_lat(32'h1, 32'hFFFF_FFFF), 1'b1, 1'b0);
    do_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, FULL_LAT, 1'b1, 1'b0);
    do_div("d100_7", 32'd100, 32'd7, FULL_LAT, 1'b0, 1'b0);
    do_div("b2b_max_1", 32'hFFFF_FFFF, 32'd1, FULL_LAT + 1, 1'b1, 1'b0);
    do_div("d5_0", 32'd5, 32'd0, 1, 1'b1, 1'b0);
`ifdef ARMLEOCPU_DIVIDER_EARLY_EXIT_EN
    do_div("d3_10", 32'd3, 32'd10, 1, 1'b1, 1'b0);
`else
    do_div("d3_10", 32'd3, 32'd10, FULL_LAT, 1'b1, 1'b0);
`endif

    do_div("d1000_3", 32'd1000, 32'd3, FULL_LAT, 1'b1, 1'b0);
    abort_div("abort_valid", 1'b0, 32'd333, 32'd1);
    abort_div("abort_rst", 1'b1, 32'd0, 32'd0);

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = $urandom;
      case (n % 4)
        0: b = 32'(b >> $urandom_range(31, 0));
        1: b = (n % 8 == 1) ? 32'd0 : 32'(b & 32'hFF);
        2: a = 32'(a >> $urandom_range(31, 16));
        default: ;
      endcase
      do_div("rand", a, b, nominal_lat(a, b), 1'b1, (n % 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
